// File: rtl/ext_pipe.sv
// Pipelined immediate extender. A 2-entry FIFO of {ext, tag} uses a valid/ready handshake
// on both sides. All outputs come from registers, so no path runs from the inputs to ext.
module ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       EOp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext,
    output logic [TAG_W-1:0] out_tag
);

    function automatic logic [OUT_W-1:0] f_extend(input logic [IMM_W-1:0] imm_v,
                                                  input logic [1:0]       mode_v);
        logic [OUT_W-1:0] sext_v;
        sext_v = {{(OUT_W-IMM_W){imm_v[IMM_W-1]}}, imm_v};
        case (mode_v)
            2'b00:   f_extend = {{(OUT_W-IMM_W){1'b0}}, imm_v};
            2'b01:   f_extend = sext_v;
            2'b10:   f_extend = {imm_v, {(OUT_W-IMM_W){1'b0}}};
            2'b11:   f_extend = sext_v << SHIFT;
            default: f_extend = {OUT_W{1'b0}};
        endcase
    endfunction

    logic [OUT_W-1:0] r_ext_mem [2];
    logic [TAG_W-1:0] r_tag_mem [2];
    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_ext;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_push;
    logic             w_pop;
    logic [OUT_W-1:0] w_ext_new;
    logic [OUT_W-1:0] w_ext_mem_nxt [2];
    logic [TAG_W-1:0] w_tag_mem_nxt [2];
    logic [1:0]       w_count_nxt;
    logic             w_wr_ptr_nxt;
    logic             w_rd_ptr_nxt;
    logic [OUT_W-1:0] w_ext_nxt;
    logic [TAG_W-1:0] w_out_tag_nxt;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ext       = r_ext;
    assign out_tag   = r_out_tag;

    // Next-state of the FIFO; the output registers load the head the FIFO will have after this edge.
    always_comb begin
        w_push        = in_valid && r_in_ready;
        w_pop         = r_out_valid && out_ready;
        w_ext_new     = f_extend(imm, EOp);
        w_ext_mem_nxt = r_ext_mem;
        w_tag_mem_nxt = r_tag_mem;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_count_nxt   = r_count;
        w_ext_nxt     = r_ext;
        w_out_tag_nxt = r_out_tag;
        if (w_push) begin
            w_ext_mem_nxt[r_wr_ptr] = w_ext_new;
            w_tag_mem_nxt[r_wr_ptr] = in_tag;
            w_wr_ptr_nxt            = ~r_wr_ptr;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end
        if (w_pop) begin
            w_rd_ptr_nxt = ~r_rd_ptr;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
        // An empty FIFO keeps showing the last head rather than a stale slot.
        if (w_count_nxt != 2'd0) begin
            w_ext_nxt     = w_ext_mem_nxt[w_rd_ptr_nxt];
            w_out_tag_nxt = w_tag_mem_nxt[w_rd_ptr_nxt];
        end else begin
            w_ext_nxt     = r_ext;
            w_out_tag_nxt = r_out_tag;
        end
    end

    // FIFO state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ext_mem[0] <= {OUT_W{1'b0}};
            r_ext_mem[1] <= {OUT_W{1'b0}};
            r_tag_mem[0] <= {TAG_W{1'b0}};
            r_tag_mem[1] <= {TAG_W{1'b0}};
            r_count      <= 2'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_ext        <= {OUT_W{1'b0}};
            r_out_tag    <= {TAG_W{1'b0}};
        end else begin
            r_ext_mem    <= w_ext_mem_nxt;
            r_tag_mem    <= w_tag_mem_nxt;
            r_count      <= w_count_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_in_ready   <= (w_count_nxt != 2'd2);
            r_out_valid  <= (w_count_nxt != 2'd0);
            r_ext        <= w_ext_nxt;
            r_out_tag    <= w_out_tag_nxt;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe: mode sweep, backpressure, streaming,
// mid-operation reset, idle behaviour and a 12->64 bit parameter set.
module tb_ext_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [1:0]  EOp;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext;
    logic [4:0]  out_tag;

    logic        p_in_valid;
    logic        p_in_ready;
    logic [11:0] p_imm;
    logic [1:0]  p_EOp;
    logic [4:0]  p_in_tag;
    logic        p_out_valid;
    logic        p_out_ready;
    logic [63:0] p_ext;
    logic [4:0]  p_out_tag;

    int n_tests;
    int n_fail;

    ext_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .EOp(EOp), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .ext(ext), .out_tag(out_tag)
    );

    ext_pipe #(.IMM_W(12), .OUT_W(64), .SHIFT(1), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .imm(p_imm), .EOp(p_EOp), .in_tag(p_in_tag),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .ext(p_ext), .out_tag(p_out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] v_imm [9];
    logic [1:0]  v_eop [9];
    logic [31:0] v_exp [9];
    logic [11:0] q_imm [3];
    logic [1:0]  q_eop [3];
    logic [63:0] q_exp [3];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        v_imm = '{16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'h8001,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        v_eop = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        v_exp = '{32'h0000ffff, 32'hffffffff, 32'hffff0000, 32'hfffffffc, 32'hfffe0004,
                  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        q_imm = '{12'h800, 12'h800, 12'h800};
        q_eop = '{2'b01, 2'b11, 2'b10};
        q_exp = '{64'hfffffffffffff800, 64'hfffffffffffff000, 64'h8000000000000000};

        reset = 1'b0;
        in_valid = 1'b0; imm = 16'h0000; EOp = 2'b00; in_tag = 5'd0; out_ready = 1'b0;
        p_in_valid = 1'b0; p_imm = 12'h000; p_EOp = 2'b00; p_in_tag = 5'd0; p_out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_ext", {32'd0, ext}, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);
        reset = 1'b1;

        // Idle: out_ready toggling with nothing pushed.
        for (int i = 0; i < 4; i++) begin
            out_ready = ~out_ready;
            step();
            check("idle_out_valid", {63'd0, out_valid}, 64'd0);
            check("idle_ext", {32'd0, ext}, 64'd0);
        end

        // Wide parameter set.
        for (int i = 0; i < 3; i++) begin
            p_in_valid = 1'b1; p_imm = q_imm[i]; p_EOp = q_eop[i]; p_in_tag = 5'(i + 20);
            step();
            p_in_valid = 1'b0;
            check("p64_valid", {63'd0, p_out_valid}, 64'd1);
            check("p64_ext", p_ext, q_exp[i]);
            check("p64_tag", {59'd0, p_out_tag}, 64'(i + 20));
        end

        // Mode sweep.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; imm = v_imm[i]; EOp = v_eop[i]; in_tag = 5'(i + 1);
            step();
            in_valid = 1'b0;
            check("mode_valid", {63'd0, out_valid}, 64'd1);
            check("mode_ext", {32'd0, ext}, {32'd0, v_exp[i]});
            check("mode_tag", {59'd0, out_tag}, 64'(i + 1));
        end
        step();
        check("mode_drain", {63'd0, out_valid}, 64'd0);

        // Backpressure: tags 1,2,3 with imm equal to the tag, zero-extended.
        out_ready = 1'b0;
        EOp = 2'b00;
        in_valid = 1'b1; imm = 16'd1; in_tag = 5'd1;
        step();
        check("bp_ready1", {63'd0, in_ready}, 64'd1);
        imm = 16'd2; in_tag = 5'd2;
        step();
        check("bp_ready2", {63'd0, in_ready}, 64'd0);
        imm = 16'd3; in_tag = 5'd3;
        step();
        check("bp_held_ready", {63'd0, in_ready}, 64'd0);
        check("bp_stall_tag", {59'd0, out_tag}, 64'd1);
        check("bp_stall_ext", {32'd0, ext}, 64'd1);
        step();
        check("bp_stall_ext2", {32'd0, ext}, 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_out2_tag", {59'd0, out_tag}, 64'd2);
        check("bp_out2_ext", {32'd0, ext}, 64'd2);
        check("bp_ready_back", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_out3_tag", {59'd0, out_tag}, 64'd3);
        check("bp_out3_ext", {32'd0, ext}, 64'd3);
        step();
        check("bp_empty", {63'd0, out_valid}, 64'd0);
        check("bp_hold_ext", {32'd0, ext}, 64'd3);

        // Streaming: one push and one pop each cycle.
        EOp = 2'b01;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; imm = 16'(i); in_tag = 5'(i + 8);
            step();
            check("str_valid", {63'd0, out_valid}, 64'd1);
            check("str_ready", {63'd0, in_ready}, 64'd1);
            check("str_ext", {32'd0, ext}, 64'(i));
            check("str_tag", {59'd0, out_tag}, 64'(i + 8));
        end
        in_valid = 1'b0;
        step();
        check("str_drain", {63'd0, out_valid}, 64'd0);

        // Reset mid-operation with the FIFO full.
        out_ready = 1'b0;
        EOp = 2'b00;
        in_valid = 1'b1; imm = 16'h1234; in_tag = 5'd9;
        step();
        imm = 16'h5678; in_tag = 5'd10;
        step();
        in_valid = 1'b0;
        check("rm_full", {63'd0, in_ready}, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        check("rm_out_valid", {63'd0, out_valid}, 64'd0);
        check("rm_ext", {32'd0, ext}, 64'd0);
        check("rm_tag", {59'd0, out_tag}, 64'd0);
        check("rm_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; imm = 16'h00aa; in_tag = 5'd4;
        step();
        in_valid = 1'b0;
        check("rm_first_ext", {32'd0, ext}, 64'h00aa);
        check("rm_first_tag", {59'd0, out_tag}, 64'd4);
        step();
        check("rm_no_stale", {63'd0, out_valid}, 64'd0);
        check("rm_hold_ext", {32'd0, ext}, 64'h00aa);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Takes an IMM_W-bit immediate, an EOp mode and a sideband tag, and produces an OUT_W-bit extended value.
- Sits between decode and the execute operand muxes.
- Uses a valid/ready handshake and a 2-entry output skid buffer, so decode can stall independently of execute at full throughput.

Parameters:
- IMM_W, 16, immediate width in bits; must be at least 2 and less than OUT_W.
- OUT_W, 32, extended output width in bits.
- SHIFT, 2, left-shift amount applied in mode 2'b11; must be less than OUT_W.
- TAG_W, 5, width of the sideband tag carried alongside each item (for example, destination register).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  upstream presents a valid item.
- in_ready  out  1  block can accept an item this cycle.
- imm  in  IMM_W  immediate field.
- EOp  in  2  extension mode.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  buffer head holds a valid item.
- out_ready  in  1  downstream accepts the head this cycle.
- ext  out  OUT_W  extended result at the buffer head.
- out_tag  out  TAG_W  tag of the head item.

Behaviour:
- Mode encoding, computed combinationally from imm and EOp at accept time:
  - 2'b00: zero-extend imm to OUT_W.
  - 2'b01: sign-extend using imm[IMM_W-1].
  - 2'b10: load-upper. imm occupies bits [OUT_W-1:OUT_W-IMM_W]; the low bits are 0.
  - 2'b11: sign-extend, then shift left by SHIFT and truncate to OUT_W; vacated low bits are 0.
- Buffer:
  - 2-entry FIFO of {ext, tag}, with a 2-bit count (0..2), a 1-bit write pointer and a 1-bit read pointer.
- Handshake:
  - Push when in_valid && in_ready; pop when out_valid && out_ready.
  - in_ready = (count != 2). It is a function of registered state only and has no combinational path from out_ready.
  - out_valid = (count != 0).
  - ext and out_tag always show the head entry. When count == 0 they hold the last value.
- Latency:
  - An item accepted at edge N is visible on ext with out_valid = 1 after edge N, i.e. one cycle.
  - No combinational path runs from the inputs to ext.
- Throughput:
  - Sustained push plus pop every cycle holds count at 1 and gives 1 item per cycle.
- Count update per edge:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together (possible only when count == 1): count unchanged. The new entry is written at wr_ptr and the head advances.
  - At count == 2 no push can occur. A pop that edge drops count to 1, and in_ready rises on the next cycle.
  - At count == 0 no pop can occur. ext and out_tag are held.
- Ordering: strict FIFO, and the tag always stays paired with its own result.
- Stability: while out_valid && !out_ready, ext and out_tag do not change.
- Reset (asynchronous, any time, including mid-transfer):
  - count = 0, pointers = 0, both entries = 0.
  - out_valid = 0, ext = 0, out_tag = 0, in_ready = 1.
  - Items held in the buffer are discarded.
  - No push or pop occurs while reset = 0.
  - Release is synchronous-safe: the first push is possible on the first rising edge after reset goes to 1.
- Inputs are sampled only on an accepting edge. imm, EOp and in_tag may change freely when in_valid = 0.

Test Plan:
1. Mode sweep, defaults, out_ready = 1. Each case: in_valid = 1 for one cycle with the stated inputs; next cycle requires out_valid = 1, ext equal to the value below, and out_tag equal to the in_tag sent with it.
   - imm = 16'hffff, EOp = 00, 01, 10, 11 -> ext = 32'h0000ffff, 32'hffffffff, 32'hffff0000, 32'hfffffffc.
   - imm = 16'h8001, EOp = 11 -> 32'hfffe0004.
   - imm = 16'h0000, all modes -> 32'h00000000.
2. Backpressure. out_ready = 0; push tags 1, 2, 3 back to back.
   - in_ready falls after the second accept; tag 3 is held off.
   - Then raise out_ready: tags emerge 1, 2, 3 in order, with ext stable while stalled.
3. Streaming. in_valid = out_ready = 1 for 8 cycles with imm = 0..7 and EOp = 01.
   - Required: 8 outputs 0..7 on consecutive cycles, and count stays at 1.
4. Reset mid-operation. Fill to count = 2, then assert reset = 0 asynchronously between edges.
   - Required immediately: out_valid = 0, ext = 0, in_ready = 1.
   - After release, the first pushed item is the first output; no stale data appears.
5. Parametrisation. IMM_W = 12, OUT_W = 64, SHIFT = 1, imm = 12'h800.
   - EOp = 01 -> 64'hfffffffffffff800.
   - EOp = 11 -> 64'hfffffffffffff000.
   - EOp = 10 -> 64'h8000000000000000.
6. Empty/idle. out_ready toggled while in_valid = 0.
   - Required: out_valid stays 0 and ext holds its last value (0 after reset).
